// File: rtl/am_lane_tx.sv
// am_lane_tx: per-lane TX alignment marker insertion for a multi-lane 64b/66b PCS.
// Every AM_GAP data blocks the upstream is stalled for one slot and the lane marker is sent,
// carrying the running BIP3/BIP7 parity over everything sent since the previous marker.
// Optional feature: define AM_TX_BIP_ERR_INJ_EN to add bip_err_i, which corrupts BIP3 bit 0
// of the marker sent on that cycle (the parity accumulator keeps the true value).
module am_lane_tx #(
    parameter int unsigned BLOCK_W = 66,
    parameter int unsigned AM_GAP  = 16383,
    parameter logic [23:0] AM_M    = 24'h4776_90,
    parameter int unsigned CNT_W   = $clog2(AM_GAP)
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               ready_i,
`ifdef AM_TX_BIP_ERR_INJ_EN
    input  logic               bip_err_i,
`endif
    input  logic [BLOCK_W-1:0] data_i,
    output logic               ready_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               am_v_o
);

    logic               am_slot_q, am_slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         bip_q, bip_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               am_v_q, am_v_d;

    logic [7:0]         bip3_tx;
    logic [BLOCK_W-1:0] am_clean;
    logic [BLOCK_W-1:0] am_tx;

    // Bit-interleaved parity of one block: payload bits fold onto 8 lanes, sync header
    // bits land on parity bits 3 and 4.
    function automatic logic [7:0] fold(input logic [BLOCK_W-1:0] b);
        logic [7:0] f;
        f = 8'h00;
        for (int k = 0; k < 8; k++) begin
            f = f ^ b[2 + 8*k +: 8];
        end
        f[3] = f[3] ^ b[0];
        f[4] = f[4] ^ b[1];
        return f;
    endfunction

    // Marker contents; the clean copy feeds the parity accumulator.
    always_comb begin
        bip3_tx = bip_q;
`ifdef AM_TX_BIP_ERR_INJ_EN
        bip3_tx[0] = bip_q[0] ^ bip_err_i;
`endif
        am_clean = {~bip_q, ~AM_M, bip_q, AM_M, 2'b01};
        am_tx    = {~bip_q, ~AM_M, bip3_tx, AM_M, 2'b01};
    end

    // Next-state: hold unless the gearbox takes a block; choose marker or data slot.
    always_comb begin
        am_slot_d = am_slot_q;
        cnt_d     = cnt_q;
        bip_d     = bip_q;
        data_d    = data_q;
        am_v_d    = am_v_q;
        if (ready_i) begin
            if (am_slot_q) begin
                data_d    = am_tx;
                am_v_d    = 1'b1;
                bip_d     = fold(am_clean);
                cnt_d     = '0;
                am_slot_d = 1'b0;
            end else begin
                data_d = data_i;
                am_v_d = 1'b0;
                bip_d  = bip_q ^ fold(data_i);
                if (cnt_q == CNT_W'(AM_GAP - 1)) begin
                    am_slot_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State register with synchronous active-low reset; first slot after reset is a marker.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            am_slot_q <= 1'b1;
            cnt_q     <= '0;
            bip_q     <= 8'h00;
            data_q    <= '0;
            am_v_q    <= 1'b0;
        end else begin
            am_slot_q <= am_slot_d;
            cnt_q     <= cnt_d;
            bip_q     <= bip_d;
            data_q    <= data_d;
            am_v_q    <= am_v_d;
        end
    end

    // Gate with nreset so nothing is consumed on the cycle reset is first asserted.
    always_comb begin
        ready_o = ready_i & ~am_slot_q & nreset;
        data_o  = data_q;
        am_v_o  = am_v_q;
    end

endmodule
